// File: rtl/tictac_pkg.sv
// Shared definitions for the tic-tac-toe board datapath: cell codes and
// the move-controller FSM state encoding.
package tictac_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_P1    = 2'b01;
   localparam logic [1:0] CELL_P2    = 2'b10;

   typedef enum logic [1:0] {
      TURN_P1 = 2'd0,
      TURN_P2 = 2'd1,
      FULL    = 2'd2
   } state_e;

endpackage : tictac_pkg

// File: rtl/move_onehot_check.sv
// Combinational qualifier for one player's move vector: reports whether the
// vector is nonzero, whether exactly one bit is set, and the set bit's index
// (index is only meaningful when onehot_o is high).
module move_onehot_check #(
   parameter int CELLS = 9,
   parameter int IW    = $clog2(CELLS)
) (
   input  logic [CELLS-1:0] vec_i,
   output logic             nonzero_o,
   output logic             onehot_o,
   output logic [IW-1:0]    idx_o
);

   // Classify the vector and encode the selected cell position.
   always_comb begin
      nonzero_o = (vec_i != '0);
      // Clearing the lowest set bit leaves zero only for a single-bit vector.
      onehot_o  = nonzero_o && ((vec_i & (vec_i - CELLS'(1))) == '0);
      idx_o     = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (vec_i[i]) idx_o = IW'(i);
      end
   end

endmodule : move_onehot_check

// File: rtl/board_move_ctrl.sv
// N x N tic-tac-toe board controller: holds the board and the turn, judges
// each one-hot move request against the registered state and reports the
// outcome with a one-cycle move_ok / illegal_move pulse.
// Optional feature macro: ILLEGAL_CNT_EN adds a saturating illegal_cnt output.
module board_move_ctrl
   import tictac_pkg::*;
#(
   parameter int N            = 3,
   parameter int FIRST_PLAYER = 0,
   localparam int CELLS       = N * N,
   localparam int CW          = $clog2(CELLS + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               new_game,
   input  logic [CELLS-1:0]   PL1_en,
   input  logic [CELLS-1:0]   PL2_en,
   output logic [2*CELLS-1:0] board,
   output logic               turn,
   output logic               move_ok,
   output logic               illegal_move,
   output logic [CW-1:0]      move_cnt,
   output logic               board_full
`ifdef ILLEGAL_CNT_EN
   ,
   output logic [7:0]         illegal_cnt
`endif
);

   localparam int     IW          = $clog2(CELLS);
   localparam state_e START_STATE = (FIRST_PLAYER != 0) ? TURN_P2 : TURN_P1;
   localparam logic   START_TURN  = (FIRST_PLAYER != 0);

   state_e             state_q, state_d;
   logic [2*CELLS-1:0] board_q, board_d;
   logic               turn_q, turn_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               ok_q, ok_d;
   logic               ill_q, ill_d;

   logic               p1_nz, p1_oh, p2_nz, p2_oh;
   logic [IW-1:0]      p1_idx, p2_idx, sel_idx;
   logic               req, legal;

   move_onehot_check #(.CELLS(CELLS), .IW(IW)) u_p1_check (
      .vec_i     (PL1_en),
      .nonzero_o (p1_nz),
      .onehot_o  (p1_oh),
      .idx_o     (p1_idx)
   );

   move_onehot_check #(.CELLS(CELLS), .IW(IW)) u_p2_check (
      .vec_i     (PL2_en),
      .nonzero_o (p2_nz),
      .onehot_o  (p2_oh),
      .idx_o     (p2_idx)
   );

   // Judge the request and compute next board, turn, count, state and pulses.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      board_d = board_q;
      turn_d  = turn_q;
      cnt_d   = cnt_q;
      ok_d    = 1'b0;
      ill_d   = 1'b0;

      req     = p1_nz | p2_nz;
      sel_idx = (state_q == TURN_P2) ? p2_idx : p1_idx;

      // Only the player whose turn it is may move, alone and with one cell; FULL accepts nothing.
      unique case (state_q)
         TURN_P1: legal = p1_nz & ~p2_nz & p1_oh;
         TURN_P2: legal = p2_nz & ~p1_nz & p2_oh;
         default: legal = 1'b0;
      endcase
      legal = legal && (board_q[2*int'(sel_idx) +: 2] == CELL_EMPTY);

      if (new_game) begin
         // A restart overrides any request presented in the same cycle.
         state_d = START_STATE;
         board_d = '0;
         turn_d  = START_TURN;
         cnt_d   = '0;
      end else if (req) begin
         if (legal) begin
            board_d[2*int'(sel_idx) +: 2] = (state_q == TURN_P1) ? CELL_P1 : CELL_P2;
            cnt_d   = cnt_q + CW'(1);
            turn_d  = ~turn_q;
            ok_d    = 1'b1;
            if (cnt_d == CW'(CELLS)) state_d = FULL;
            else                     state_d = (state_q == TURN_P1) ? TURN_P2 : TURN_P1;
         end else begin
            ill_d = 1'b1;
         end
      end
   end

   // State, board, counter and pulse registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= START_STATE;
         board_q <= '0;
         turn_q  <= START_TURN;
         cnt_q   <= '0;
         ok_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q <= state_d;
         board_q <= board_d;
         turn_q  <= turn_d;
         cnt_q   <= cnt_d;
         ok_q    <= ok_d;
         ill_q   <= ill_d;
      end
   end

`ifdef ILLEGAL_CNT_EN
   logic [7:0] ill_cnt_q;

   // Saturating count of rejected requests, updated together with the pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                             ill_cnt_q <= '0;
      else if (new_game)                   ill_cnt_q <= '0;
      else if (ill_d && ill_cnt_q != 8'hFF) ill_cnt_q <= ill_cnt_q + 8'd1;
   end

   assign illegal_cnt = ill_cnt_q;
`endif

   assign board        = board_q;
   assign turn         = turn_q;
   assign move_ok      = ok_q;
   assign illegal_move = ill_q;
   assign move_cnt     = cnt_q;
   assign board_full   = (cnt_q == CW'(CELLS));

endmodule : board_move_ctrl

// File: tb/tb_board_move_ctrl.sv
// Self-checking bench for board_move_ctrl: randomized and directed requests
// compared against a cell-array reference model of the game rules.
module tb_board_move_ctrl;

   localparam int TB_N  = 3;
   localparam int TB_FP = 0;
   localparam int CELLS = TB_N * TB_N;
   localparam int CW    = $clog2(CELLS + 1);

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               new_game = 1'b0;
   logic [CELLS-1:0]   PL1_en = '0;
   logic [CELLS-1:0]   PL2_en = '0;
   logic [2*CELLS-1:0] board;
   logic               turn, move_ok, illegal_move, board_full;
   logic [CW-1:0]      move_cnt;
`ifdef ILLEGAL_CNT_EN
   logic [7:0]         illegal_cnt;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   // Reference model: one entry per cell (0 empty, 1 P1, 2 P2).
   int m_cell [CELLS];
   int m_turn, m_cnt, m_ill_cnt;
   bit e_ok, e_ill;

   board_move_ctrl #(.N(TB_N), .FIRST_PLAYER(TB_FP)) dut (
      .clk          (clk),
      .rst          (rst),
      .new_game     (new_game),
      .PL1_en       (PL1_en),
      .PL2_en       (PL2_en),
      .board        (board),
      .turn         (turn),
      .move_ok      (move_ok),
      .illegal_move (illegal_move),
      .move_cnt     (move_cnt),
      .board_full   (board_full)
`ifdef ILLEGAL_CNT_EN
      ,
      .illegal_cnt  (illegal_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      for (int i = 0; i < CELLS; i++) m_cell[i] = 0;
      m_turn = TB_FP;
      m_cnt  = 0;
      m_ill_cnt = 0;
   endtask

   // Apply the game rules to one request as the controller would see it at the edge.
   task automatic model_step(input logic [CELLS-1:0] p1, input logic [CELLS-1:0] p2, input bit ng);
      bit ok;
      int player, idx;
      logic [CELLS-1:0] v;
      e_ok = 0;
      e_ill = 0;
      if (ng) begin
         model_clear();
      end else if (p1 != 0 || p2 != 0) begin
         ok = 1;
         player = (p1 != 0) ? 0 : 1;
         v = (player == 0) ? p1 : p2;
         if (p1 != 0 && p2 != 0) ok = 0;
         if ($countones(v) != 1) ok = 0;
         if (player != m_turn) ok = 0;
         if (m_cnt == CELLS) ok = 0;
         idx = 0;
         for (int i = 0; i < CELLS; i++) if (v[i]) idx = i;
         if (m_cell[idx] != 0) ok = 0;
         if (ok) begin
            m_cell[idx] = player + 1;
            m_cnt++;
            m_turn = 1 - m_turn;
            e_ok = 1;
         end else begin
            e_ill = 1;
            if (m_ill_cnt < 255) m_ill_cnt++;
         end
      end
   endtask

   // Compare every DUT output with the model.
   task automatic compare_all(input string tag);
      logic [2*CELLS-1:0] eb;
      for (int i = 0; i < CELLS; i++) eb[2*i +: 2] = 2'(m_cell[i]);
      tests_run++;
      if (board !== eb) begin
         tests_failed++;
         $display("FAIL %s board: got %h expected %h", tag, board, eb);
      end
      tests_run++;
      if (turn !== 1'(m_turn)) begin
         tests_failed++;
         $display("FAIL %s turn: got %b expected %0d", tag, turn, m_turn);
      end
      tests_run++;
      if (move_cnt !== CW'(m_cnt)) begin
         tests_failed++;
         $display("FAIL %s move_cnt: got %0d expected %0d", tag, move_cnt, m_cnt);
      end
      tests_run++;
      if (move_ok !== e_ok || illegal_move !== e_ill) begin
         tests_failed++;
         $display("FAIL %s pulses ok/ill: got %b/%b expected %b/%b", tag, move_ok, illegal_move, e_ok, e_ill);
      end
      tests_run++;
      if (board_full !== (m_cnt == CELLS)) begin
         tests_failed++;
         $display("FAIL %s board_full: got %b expected %b", tag, board_full, m_cnt == CELLS);
      end
`ifdef ILLEGAL_CNT_EN
      tests_run++;
      if (illegal_cnt !== 8'(m_ill_cnt)) begin
         tests_failed++;
         $display("FAIL %s illegal_cnt: got %0d expected %0d", tag, illegal_cnt, m_ill_cnt);
      end
`endif
   endtask

   // Present one request for one clock edge, then compare against the model.
   task automatic cycle(input logic [CELLS-1:0] p1, input logic [CELLS-1:0] p2, input bit ng, input string tag);
      @(negedge clk);
      PL1_en   = p1;
      PL2_en   = p2;
      new_game = ng;
      model_step(p1, p2, ng);
      @(posedge clk);
      #1;
      compare_all(tag);
   endtask

   task automatic test_reset();
      @(negedge clk);
      PL1_en = '0; PL2_en = '0; new_game = 0;
      rst = 1;
      #1;
      model_clear();
      e_ok = 0; e_ill = 0;
      compare_all("reset");
      @(negedge clk);
      rst = 0;
   endtask

   task automatic test_basic();
      cycle(9'h001, 9'h000, 0, "p1_cell0");
      tests_run++;
      if (board[1:0] !== 2'b01 || turn !== 1'b1) begin
         tests_failed++;
         $display("FAIL p1_cell0 direct: got cell %b turn %b expected 01 1", board[1:0], turn);
      end
      cycle(9'h000, 9'h001, 0, "p2_occupied");
      cycle(9'h002, 9'h004, 0, "both_players");
      cycle(9'h000, 9'h000, 0, "idle");
      cycle(9'h000, 9'h003, 0, "multi_hot_p2");
      cycle(9'h003, 9'h000, 0, "multi_hot_p1");
   endtask

   task automatic test_fill();
      int perm [CELLS];
      int j, t;
      cycle('0, '0, 1, "fill_new_game");
      for (int i = 0; i < CELLS; i++) perm[i] = i;
      for (int i = CELLS - 1; i > 0; i--) begin
         j = $urandom_range(0, i);
         t = perm[i]; perm[i] = perm[j]; perm[j] = t;
      end
      // Back-to-back legal moves, alternating players, one per cycle.
      for (int i = 0; i < CELLS; i++) begin
         if (m_turn == 0) cycle(CELLS'(1) << perm[i], '0, 0, "fill_move");
         else             cycle('0, CELLS'(1) << perm[i], 0, "fill_move");
      end
      tests_run++;
      if (board_full !== 1'b1 || move_cnt !== CW'(CELLS)) begin
         tests_failed++;
         $display("FAIL full_flag: got full %b cnt %0d expected 1 %0d", board_full, move_cnt, CELLS);
      end
      cycle(9'h001, '0, 0, "full_p1_req");
      cycle('0, 9'h100, 0, "full_p2_req");
      cycle('0, '0, 1, "full_new_game");
   endtask

   task automatic test_new_game_priority();
      cycle(9'h010, '0, 1, "ng_vs_request");
      cycle(9'h010, '0, 0, "after_ng_move");
   endtask

   task automatic test_async_reset();
      @(negedge clk);
      PL1_en = '0; PL2_en = 9'h100;
      #2;
      rst = 1;
      #1;
      model_clear();
      e_ok = 0; e_ill = 0;
      compare_all("async_rst");
      @(posedge clk);
      #1;
      compare_all("async_rst_held");
      @(negedge clk);
      PL2_en = '0;
      rst = 0;
   endtask

   task automatic test_random();
      logic [CELLS-1:0] v, p1, p2;
      int r;
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 19);
         v = CELLS'(1) << $urandom_range(0, CELLS - 1);
         p1 = '0; p2 = '0;
         if (r < 12) begin
            if (m_turn == 0) p1 = v; else p2 = v;
         end else if (r < 14) begin
            if (m_turn == 0) p2 = v; else p1 = v;
         end else if (r < 16) begin
            p1 = v; p2 = CELLS'(1) << $urandom_range(0, CELLS - 1);
         end else if (r < 18) begin
            if ($urandom_range(0, 1) == 0) p1 = CELLS'($urandom); else p2 = CELLS'($urandom);
         end
         cycle(p1, p2, ($urandom_range(0, 39) == 0), "random");
      end
   endtask

`ifdef ILLEGAL_CNT_EN
   task automatic test_illegal_cnt();
      cycle('0, '0, 1, "cnt_new_game");
      if (TB_FP == 0) cycle('0, 9'h001, 0, "cnt_wrong_first");
      else            cycle(9'h001, '0, 0, "cnt_wrong_first");
      for (int k = 0; k < 300; k++) cycle(9'h003, '0, 0, "cnt_saturate");
      tests_run++;
      if (illegal_cnt !== 8'd255) begin
         tests_failed++;
         $display("FAIL cnt_sat: got %0d expected 255", illegal_cnt);
      end
      cycle('0, '0, 1, "cnt_clear");
   endtask
`endif

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_fill();
      test_new_game_priority();
      test_async_reset();
      test_random();
`ifdef ILLEGAL_CNT_EN
      test_illegal_cnt();
`endif
      test_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule : tb_board_move_ctrl
